// File: rtl/display_scan_controller.sv
// Double-dabble binary-to-BCD converter feeding a three-digit multiplexed
// 7-segment scan with programmable refresh and optional leading-zero blanking.
module display_scan_controller #(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_ZEROS = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [8:0] in_val,
  output logic       in_ready,
  output logic       busy,
  output logic [3:0] BCD,
  output logic [3:0] an
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t        state_p0, state_nxt;
  logic [8:0]    bin_p0;
  logic [11:0]   acc_p0;
  logic [3:0]    cnt_p0;
  logic [3:0]    hund_p0, tens_p0, ones_p0;
  logic [PW-1:0] presc_p0;
  logic [1:0]    slot_p0, slot_nxt;
  logic          load, done, presc_wrap;
  logic [11:0]   acc_sh;
  logic [8:0]    bin_sh;
  logic [3:0]    bcd_nxt, an_nxt;

  function automatic logic [11:0] add3(input logic [11:0] a);
    logic [11:0] r;
    r = a;
    for (int i = 0; i < 3; i++) begin
      if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign {acc_sh, bin_sh} = {add3(acc_p0), bin_p0} << 1;
  assign in_ready = (state_p0 == IDLE);
  assign busy     = ~in_ready;

  always_comb begin
    state_nxt = state_p0;
    load      = 1'b0;
    done      = 1'b0;
    case (state_p0)
      IDLE: if (in_valid) begin
        load      = 1'b1;
        state_nxt = CONV;
      end
      CONV: if (cnt_p0 == 4'd1) begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_p0 <= IDLE;
    else     state_p0 <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (load) begin
      bin_p0 <= in_val;
      acc_p0 <= '0;
      cnt_p0 <= 4'd9;
    end else if (state_p0 == CONV) begin
      bin_p0 <= bin_sh;
      acc_p0 <= acc_sh;
      cnt_p0 <= cnt_p0 - 4'd1;
    end
  end

  // Display digits latch only the finished conversion result.
  always_ff @(posedge clk) begin
    if (rst) begin
      hund_p0 <= '0;
      tens_p0 <= '0;
      ones_p0 <= '0;
    end else if (done) begin
      {hund_p0, tens_p0, ones_p0} <= acc_sh;
    end
  end

  assign presc_wrap = (presc_p0 == PRESC_MAX);

  always_comb begin
    slot_nxt = slot_p0;
    if (presc_wrap) slot_nxt = (slot_p0 == 2'd2) ? 2'd0 : slot_p0 + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_p0 <= '0;
      slot_p0  <= '0;
    end else begin
      presc_p0 <= presc_wrap ? '0 : presc_p0 + PW'(1);
      slot_p0  <= slot_nxt;
    end
  end

  always_comb begin
    bcd_nxt = ones_p0;
    an_nxt  = 4'b1110;
    case (slot_nxt)
      2'd1: begin
        bcd_nxt = tens_p0;
        an_nxt  = (BLANK_ZEROS && hund_p0 == 4'd0 && tens_p0 == 4'd0) ? 4'b1111 : 4'b1101;
      end
      2'd2: begin
        bcd_nxt = hund_p0;
        an_nxt  = (BLANK_ZEROS && hund_p0 == 4'd0) ? 4'b1111 : 4'b1011;
      end
      default: ;
    endcase
  end

  // Registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      BCD <= 4'd0;
      an  <= 4'b1110;
    end else begin
      BCD <= bcd_nxt;
      an  <= an_nxt;
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench: stimulus queues hand-computed digits per load; a monitor
// checks every scanned slot of a blanking and a non-blanking instance.
module tb_display_scan_controller;

  localparam int RD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [8:0] in_val = '0;
  logic       in_ready0, busy0, in_ready1, busy1;
  logic [3:0] bcd0, an0, bcd1, an1;

  typedef struct {logic [3:0] h; logic [3:0] t; logic [3:0] o;} digits_t;
  digits_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  display_scan_controller #(.REFRESH_DIV(RD), .BLANK_ZEROS(1'b1)) dut_blank (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_val(in_val),
    .in_ready(in_ready0), .busy(busy0), .BCD(bcd0), .an(an0));

  display_scan_controller #(.REFRESH_DIV(RD), .BLANK_ZEROS(1'b0)) dut_full (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_val(in_val),
    .in_ready(in_ready1), .busy(busy1), .BCD(bcd1), .an(an1));

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_an(input int slot, input digits_t d, input bit blank);
    if (slot == 1) return (blank && d.h == 0 && d.t == 0) ? 4'b1111 : 4'b1101;
    if (slot == 2) return (blank && d.h == 0) ? 4'b1111 : 4'b1011;
    return 4'b1110;
  endfunction

  function automatic logic [3:0] exp_bcd(input int slot, input digits_t d);
    if (slot == 1) return d.t;
    if (slot == 2) return d.h;
    return d.o;
  endfunction

  // Monitor: tracks edges since reset to know the active slot, and takes the
  // next queued digit set when in_ready rises at conversion completion.
  initial begin
    int      n = 0;
    int      low_cnt = 0;
    int      slot;
    bit      prev_ready = 1'b1;
    bit      pend_valid = 1'b0;
    digits_t cur = '{4'd0, 4'd0, 4'd0};
    digits_t pend = '{4'd0, 4'd0, 4'd0};
    forever begin
      @(posedge clk);
      if (rst) begin
        n = 0; cur = '{4'd0, 4'd0, 4'd0}; pend_valid = 1'b0;
        prev_ready = 1'b1; low_cnt = 0;
      end else begin
        n++;
      end
      @(negedge clk);
      if (rst) continue;
      if (pend_valid) begin cur = pend; pend_valid = 1'b0; end
      slot = (n / RD) % 3;
      check("bcd_blank", bcd0, exp_bcd(slot, cur));
      check("an_blank",  an0,  exp_an(slot, cur, 1'b1));
      check("bcd_full",  bcd1, exp_bcd(slot, cur));
      check("an_full",   an1,  exp_an(slot, cur, 1'b0));
      check("busy_inv",  busy0, !in_ready0);
      check("ready_match", in_ready1, in_ready0);
      if (!in_ready0) low_cnt++;
      if (!prev_ready && in_ready0) begin
        check("busy_cycles", low_cnt, 9);
        if (exp_q.size() == 0) begin
          check("unexpected_completion", 1, 0);
        end else begin
          pend = exp_q.pop_front();
          pend_valid = 1'b1;
        end
        low_cnt = 0;
      end
      prev_ready = in_ready0;
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!in_ready0 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (!in_ready0) check("ready_timeout", 0, 1);
  endtask

  task automatic cycles(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [8:0] v, input bit push,
                      input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    wait_ready();
    in_val   = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (push) exp_q.push_back('{h, t, o});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(16);

    load(9'd345, 1'b1, 4'd3, 4'd4, 4'd5);
    cycles(36);
    load(9'd7,   1'b1, 4'd0, 4'd0, 4'd7);
    cycles(36);
    load(9'd105, 1'b1, 4'd1, 4'd0, 4'd5);
    cycles(36);
    load(9'd0,   1'b1, 4'd0, 4'd0, 4'd0);
    cycles(36);

    // Back-pressure: 200 is presented and held while 511 converts.
    wait_ready();
    in_val   = 9'd511;
    in_valid = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back('{4'd5, 4'd1, 4'd1});
    in_val = 9'd200;
    cycles(1);
    wait_ready();
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back('{4'd2, 4'd0, 4'd0});
    cycles(40);

    // Reset aborts a conversion of 480 on its 4th conversion cycle.
    load(9'd480, 1'b0, 4'd0, 4'd0, 4'd0);
    cycles(3);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    #1;
    check("ready_after_reset", in_ready0, 1);
    cycles(14);
    load(9'd99, 1'b1, 4'd0, 4'd9, 4'd9);
    cycles(40);

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
# display_scan_controller

Sequencing controller for the multiplexed 7-segment display path. It accepts a 9-bit binary value through a valid/ready handshake and converts it to hundreds/tens/ones BCD with an iterative shift-add-3 (double-dabble) engine over 9 cycles. It then time-multiplexes the three digits onto the shared `BCD`/`an` lines at a programmable refresh rate, with optional leading-zero blanking. It sits between the value producer and the BCD-to-7-segment decoder.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit slot stays active. Must be ≥1; 1 means the slot advances every clock.
- `BLANK_ZEROS`, default 1: 1 blanks leading zeros in the hundreds and tens slots; 0 shows all three digits.
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: producer has a value on `in_val`.
- `in_val` in 9: unsigned binary value, 0..511.
- `in_ready` out 1: controller can accept a value (converter idle).
- `busy` out 1: conversion in progress; equals `~in_ready`.
- `BCD` out 4: digit value for the active slot.
- `an` out 4: anode enables, active-low, one-hot-low or all ones when blanked. `an[3]` is always 1.

## Operation
- Converter FSM, two states:
  - IDLE: `in_ready`=1. On an edge with `in_valid`&&`in_ready`, capture `in_val` into the shift register, clear the 12-bit BCD accumulator, load iteration count 9, go to CONV.
  - CONV: `in_ready`=0. Each edge performs one iteration: add 3 to every accumulator nibble ≥5, then shift {acc, bin} left by 1, then decrement the count.
    - On the edge that completes the 9th iteration, copy the final hundreds/tens/ones into the display registers and go to IDLE.
- `in_valid` while in CONV is ignored. Nothing is captured, and the producer must hold its value until `in_ready`.
- The display registers change only at conversion completion; intermediate accumulator values are never displayed.
- Scan:
  - Free-running prescaler counts 0..REFRESH_DIV-1 and wraps.
  - On the wrap edge, slot advances 0 (ones) → 1 (tens) → 2 (hundreds) → 0.
  - The scan runs independently of the converter FSM.
- Registered outputs, updated every edge from the current slot (after any slot advance on that edge):
  - slot 0: `BCD`=ones, `an`=1110.
  - slot 1: `BCD`=tens, `an`=1101.
  - slot 2: `BCD`=hundreds, `an`=1011.
- Blanking, only when `BLANK_ZEROS`=1:
  - hundreds slot: `an`=1111 if hundreds==0.
  - tens slot: `an`=1111 if hundreds==0 and tens==0.
  - ones is never blanked.
  - `BCD` still carries the digit value when its slot is blanked.
- Arithmetic: accumulator is 12 bits, 3 nibbles. Hundreds ≤5 for the 0..511 input range, so no overflow is possible.

## Timing
- Reset, on any edge with `rst`=1, overriding everything:
  - FSM→IDLE, `in_ready`=1, `busy`=0.
  - Display registers=0, slot=0, prescaler=0.
  - `BCD`=0000, `an`=1110.
- Reset during CONV aborts the conversion. The display shows 0, and `in_ready`=1 from the first cycle after reset deasserts.
- Latency:
  - Capture at edge E0; `in_ready` low for cycles after E0 through E9.
  - Display registers update at E9, and `in_ready`=1 after E9.
  - New digits appear on `BCD`/`an` at E10, provided that slot is active.
- Throughput: one value per 10 cycles maximum. `in_valid` held high through E9 is captured again at E10.
- Simultaneous events: slot advance and conversion completion on the same edge take effect together at the next registered-output edge. There is no glitch and no mixed old/new digit in a single slot.

## Test plan
- Reset: `REFRESH_DIV`=4, `rst`=1 for 2 cycles, then 0 → `BCD`=0, `an`=1110, `in_ready`=1. Slots 1 and 2 show `an`=1111 (blanked zeros), advancing every 4 cycles.
- Load 345 (`REFRESH_DIV`=4) → `in_ready`=0 for exactly 9 cycles. Then the scan repeats ones 5/`an`=1110, tens 4/`an`=1101, hundreds 3/`an`=1011, 4 cycles each.
- Load 7 with `BLANK_ZEROS`=1 → ones 7/`an`=1110, tens and hundreds slots `an`=1111. Same load with `BLANK_ZEROS`=0 → tens 0/`an`=1101, hundreds 0/`an`=1011.
- Load 105 then 0 → 105 shows tens 0 with `an`=1101 (non-leading zero). 0 shows only the ones slot active.
- Back-pressure: capture 511, then assert `in_valid` with 200 on the next cycle and hold → 200 is not captured until `in_ready` rises. Display shows 5/1/1 first, then 2/0/0.
- Reset at the 4th CONV cycle of loading 480 → display returns to 0 with `an`=1110, `in_ready`=1 after reset, and a following load of 99 shows 9/9 with hundreds blanked.
